// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared neighbourhood bit layout, FSM encoding and edge-mask helper
package conway_pkg;

  localparam int BIT_NW = 8;
  localparam int BIT_N  = 7;
  localparam int BIT_NE = 6;
  localparam int BIT_W  = 5;
  localparam int BIT_C  = 4;
  localparam int BIT_E  = 3;
  localparam int BIT_SW = 2;
  localparam int BIT_S  = 1;
  localparam int BIT_SE = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Clears every neighbour that would fall outside the grid.
  function automatic logic [8:0] edge_mask(input logic top, input logic bottom,
                                           input logic left, input logic right);
    logic [8:0] m;
    m = '1;
    if (top)    begin m[BIT_NW] = 1'b0; m[BIT_N] = 1'b0; m[BIT_NE] = 1'b0; end
    if (bottom) begin m[BIT_SW] = 1'b0; m[BIT_S] = 1'b0; m[BIT_SE] = 1'b0; end
    if (left)   begin m[BIT_NW] = 1'b0; m[BIT_W] = 1'b0; m[BIT_SW] = 1'b0; end
    if (right)  begin m[BIT_NE] = 1'b0; m[BIT_E] = 1'b0; m[BIT_SE] = 1'b0; end
    return m;
  endfunction

endpackage

// File: rtl/conway_window_shift_line.sv
// rtl/conway_window_shift_line.sv - serial shift register, newest bit at index 0
module shift_line #(
  parameter int LEN = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           en,
  input  logic           d,
  output logic [LEN-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else if (en) begin
      q <= {q[LEN-2:0], d};
    end
  end

endmodule

// File: rtl/conway_window.sv
// rtl/conway_window.sv - raster-stream 3x3 neighbourhood generator with zero-padded edges
module conway_window
  import conway_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int COL_W  = $clog2(WIDTH),
  parameter int ROW_W  = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_cell,
  output logic             busy,
  output logic             out_valid,
  output logic [8:0]       out_status,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             frame_done
);

  localparam int N_CELLS = WIDTH * HEIGHT;
  localparam int LEN     = 2 * WIDTH + 3;
  localparam int IN_W    = $clog2(N_CELLS);
  localparam int FL_W    = $clog2(WIDTH + 1);
  localparam int PR_W    = $clog2(WIDTH + 2);

  localparam logic [IN_W-1:0]  LAST_IN  = IN_W'(N_CELLS - 1);
  localparam logic [FL_W-1:0]  LAST_FL  = FL_W'(WIDTH);
  localparam logic [PR_W-1:0]  PRIMED   = PR_W'(WIDTH + 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  state_t           state, state_next;
  logic             accept, shift_en, shift_d;
  logic [LEN-1:0]   taps;
  logic [IN_W-1:0]  in_count;
  logic [FL_W-1:0]  flush_count;
  logic [PR_W-1:0]  shift_count;
  logic             win_pend;
  logic [ROW_W-1:0] ctr_row;
  logic [COL_W-1:0] ctr_col;
  logic [8:0]       window;
  logic             unused_taps;

  assign accept = (state == IDLE) && start && !busy;

  shift_line #(.LEN(LEN)) u_line (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (shift_en),
    .d     (shift_d),
    .q     (taps)
  );

  assign window = {taps[2*WIDTH+2], taps[2*WIDTH+1], taps[2*WIDTH],
                   taps[WIDTH+2],   taps[WIDTH+1],   taps[WIDTH],
                   taps[2],         taps[1],         taps[0]};
  assign unused_taps = ^taps;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    if (in_valid && in_count == LAST_IN) state_next = FLUSH;
      FLUSH:   if (flush_count == LAST_FL) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    shift_d  = 1'b0;
    case (state)
      LOAD:    begin shift_en = in_valid; shift_d = in_cell; end
      FLUSH:   shift_en = 1'b1;
      default: ;
    endcase
  end

  // A shift only completes a window once the centre is WIDTH+1 cells deep.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      in_count    <= '0;
      flush_count <= '0;
      shift_count <= '0;
      win_pend    <= 1'b0;
      ctr_row     <= '0;
      ctr_col     <= '0;
    end else if (accept) begin
      busy        <= 1'b1;
      in_count    <= '0;
      flush_count <= '0;
      shift_count <= '0;
      win_pend    <= 1'b0;
      ctr_row     <= '0;
      ctr_col     <= '0;
    end else begin
      if (frame_done) busy <= 1'b0;
      if (state == LOAD && in_valid) in_count <= in_count + 1'b1;
      if (state == FLUSH) flush_count <= flush_count + 1'b1;
      if (shift_en && shift_count != PRIMED) shift_count <= shift_count + 1'b1;
      win_pend <= shift_en && (shift_count == PRIMED);
      if (win_pend) begin
        if (ctr_col == LAST_COL) begin
          ctr_col <= '0;
          ctr_row <= ctr_row + 1'b1;
        end else begin
          ctr_col <= ctr_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_status <= '0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= win_pend;
      frame_done <= win_pend && (ctr_row == LAST_ROW) && (ctr_col == LAST_COL);
      if (win_pend) begin
        out_status <= window & edge_mask(ctr_row == '0, ctr_row == LAST_ROW,
                                         ctr_col == '0, ctr_col == LAST_COL);
        out_row    <= ctr_row;
        out_col    <= ctr_col;
      end
    end
  end

endmodule

// File: tb/tb_conway_window.sv
// tb/tb_conway_window.sv - randomized frames checked against a grid-lookup neighbourhood model
module tb_conway_window;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_cell = 1'b0;
  logic       busy, out_valid, frame_done;
  logic [8:0] out_status;
  logic [1:0] out_row;
  logic [1:0] out_col;

  conway_window #(.WIDTH(W), .HEIGHT(H), .COL_W(2), .ROW_W(2)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_cell    (in_cell),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_status (out_status),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit grid [H][W];

  int q_row[$];
  int q_col[$];
  int q_stat[$];
  int q_fd[$];
  int done_cnt;
  bit done_seen;
  bit busy_at_done;

  always @(negedge clk) begin
    if (out_valid) begin
      q_row.push_back(int'(out_row));
      q_col.push_back(int'(out_col));
      q_stat.push_back(int'(out_status));
      q_fd.push_back(int'(frame_done));
    end
    if (frame_done) begin
      done_cnt++;
      done_seen = 1'b1;
      busy_at_done = busy;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    q_row.delete();
    q_col.delete();
    q_stat.delete();
    q_fd.delete();
    done_cnt = 0;
    done_seen = 1'b0;
    busy_at_done = 1'b0;
  endtask

  // Bit 3*dr+dc holds cell (r+1-dr, c+1-dc); outside the grid reads dead.
  function automatic int exp_status(input int r, input int c);
    int s = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        int rr = r + 1 - dr;
        int cc = c + 1 - dc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W && grid[rr][cc])
          s |= (1 << (3 * dr + dc));
      end
    return s;
  endfunction

  function automatic int life_next(input int s);
    int n = $countones(s[8:0]) - s[4];
    return (n == 3 || (s[4] == 1 && n == 2)) ? 1 : 0;
  endfunction

  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: grid[r][c] = 1'b1;
          1: grid[r][c] = (r == 1 && c == 1);
          2: grid[r][c] = (r == 1 && c < 3);
          default: grid[r][c] = 1'($urandom_range(0, 1));
        endcase
  endtask

  // mode 0: gap-free, 1: in_valid alternates 1/0, 2: random gaps
  task automatic run_frame(input string name, input int mode, input bit extra_start);
    int gaps;
    clear_obs();
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, ":busy_load"}, busy, 1);
    for (int i = 0; i < N; i++) begin
      gaps = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_cell = 1'($urandom_range(0, 1));
        tick();
      end
      in_valid = 1'b1;
      in_cell = grid[i / W][i % W];
      if (extra_start && i == 5) start = 1'b1;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
    for (int t = 0; t < 100 && !done_seen; t++) tick();
    check({name, ":frame_done_seen"}, done_seen, 1);
    tick();
    tick();
    check({name, ":busy_after"}, busy, 0);
    check({name, ":busy_at_done"}, busy_at_done, 1);
    check({name, ":n_windows"}, q_stat.size(), N);
    check({name, ":n_done"}, done_cnt, 1);
    for (int i = 0; i < q_stat.size() && i < N; i++) begin
      check($sformatf("%s:row[%0d]", name, i), q_row[i], i / W);
      check($sformatf("%s:col[%0d]", name, i), q_col[i], i % W);
      check($sformatf("%s:status[%0d]", name, i), q_stat[i], exp_status(i / W, i % W));
      check($sformatf("%s:fd[%0d]", name, i), q_fd[i], (i == N - 1) ? 1 : 0);
    end
  endtask

  initial begin
    clear_obs();
    repeat (3) tick();
    check("reset:busy", busy, 0);
    check("reset:out_valid", out_valid, 0);
    check("reset:out_status", out_status, 0);
    check("reset:out_row", out_row, 0);
    check("reset:out_col", out_col, 0);
    check("reset:frame_done", frame_done, 0);
    reset = 1'b0;
    tick();

    in_valid = 1'b1;
    repeat (6) begin
      in_cell = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("idle:no_out", q_stat.size(), 0);
    check("idle:busy", busy, 0);

    fill(0);
    run_frame("ones", 0, 1'b0);
    if (q_stat.size() == N) begin
      check("ones:(0,0)", q_stat[0], 9'h01B);
      check("ones:(0,1)", q_stat[1], 9'h03F);
      check("ones:(1,1)", q_stat[W + 1], 9'h1FF);
      check("ones:(2,3)", q_stat[N - 1], 9'h1B0);
    end

    fill(1);
    run_frame("single", 0, 1'b0);
    if (q_stat.size() == N) begin
      check("single:(0,0)", q_stat[0], 9'h001);
      check("single:(0,1)", q_stat[1], 9'h002);
      check("single:(1,1)", q_stat[W + 1], 9'h010);
      check("single:(2,2)", q_stat[2 * W + 2], 9'h100);
    end

    fill(3);
    run_frame("toggle", 1, 1'b0);

    fill(3);
    run_frame("restart", 2, 1'b1);

    clear_obs();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_cell = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("abort:busy", busy, 0);
    check("abort:out_valid", out_valid, 0);
    check("abort:out_status", out_status, 0);
    check("abort:out_row", out_row, 0);
    check("abort:out_col", out_col, 0);
    check("abort:frame_done", frame_done, 0);
    reset = 1'b0;
    clear_obs();
    repeat (20) tick();
    check("abort:no_out", q_stat.size(), 0);
    check("abort:no_done", done_cnt, 0);

    fill(3);
    run_frame("post_abort", 2, 1'b0);

    fill(2);
    run_frame("blinker", 0, 1'b0);
    for (int i = 0; i < q_stat.size() && i < N; i++)
      check($sformatf("blinker:next[%0d]", i), life_next(q_stat[i]), (i % W == 1) ? 1 : 0);

    for (int k = 0; k < 4; k++) begin
      fill(3);
      run_frame($sformatf("rand%0d", k), k % 3, k[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conway_window.md
Name: conway_window

Overview:
- Upstream neighbourhood generator for the `conway` cell-update stage.
- Accepts one frame of cell states as a raster-scan bit stream: row 0 first, column 0 first within each row.
- Emits one 9-bit 3x3 neighbourhood vector per cell, in raster order, in the exact `status[8:0]` layout `conway` consumes.
- Grid edges are zero-padded (dead cells). Internally: one shift register of 2*WIDTH+3 cells, a small FSM, and row/col counters.

Parameters:
- WIDTH, 8, cells per row (>=2)
- HEIGHT, 8, rows per frame (>=2)
- COL_W, $clog2(WIDTH), out_col width
- ROW_W, $clog2(HEIGHT), out_row width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- in_valid  in  1  in_cell valid this cycle
- in_cell  in  1  cell state, 1 = alive
- busy  out  1  high from start acceptance until frame_done
- out_valid  out  1  out_status/out_row/out_col valid, one-cycle pulse per cell
- out_status  out  9  neighbourhood of cell (out_row,out_col)
- out_row  out  ROW_W  centre cell row
- out_col  out  COL_W  centre cell column
- frame_done  out  1  one-cycle pulse, same cycle as the last out_valid

Behaviour:
- Interface decision: one clock, `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - state = IDLE; shift register all 0; counters 0.
  - busy, out_valid, frame_done = 0.
  - out_status = 0, out_row = 0, out_col = 0.
- Bit layout: index = 3*dr + dc. dr: 0 = row r+1, 1 = row r, 2 = row r-1. dc: 0 = col c+1, 1 = col c, 2 = col c-1.
  - bit 8 = (r-1,c-1); bit 4 = centre (r,c); bit 0 = (r+1,c+1).
- Shift register tap k = k-th most recent cell, newest = tap 0.
  - Taps {2W+2, 2W+1, 2W, W+2, W+1, W, 2, 1, 0} map to bits 8..0.
- Masking: any neighbour outside the grid reads 0.
  - r = 0 clears bits 8..6; r = HEIGHT-1 clears bits 2..0.
  - c = 0 clears bits 8, 5, 2; c = WIDTH-1 clears bits 6, 3, 0.
- FSM:
  - IDLE: start -> LOAD, busy = 1, in_count = 0. in_valid is ignored in IDLE.
  - LOAD: each in_valid shifts in_cell in and increments in_count. After cell W*H-1 is accepted -> FLUSH.
  - FLUSH: shifts in one 0 per cycle, exactly WIDTH+1 times, ignoring in_valid. Then -> IDLE; busy falls on the edge after frame_done.
- Emission:
  - A window completes on every shift once total shifts >= WIDTH+1. The centre cell is the one shifted in WIDTH+1 shifts earlier.
  - Registered outputs: shift at edge E -> out_valid, out_status, out_row, out_col valid after edge E+1, for one cycle.
  - out_row/out_col are the centre counters; they advance raster order and wrap col WIDTH-1 -> 0 with row+1.
- Exactly WIDTH*HEIGHT out_valid pulses per frame. frame_done coincides with the window for (HEIGHT-1, WIDTH-1).
- Gaps in in_valid stall emission; no duplicate or spurious out_valid.
- start while busy is ignored.
- Reset mid-frame aborts the frame immediately; no further out_valid pulses, no frame_done.
- No backpressure: the downstream consumer takes a result every cycle out_valid is high.

Decomposition:
- Shared package `conway_pkg`:
  - Bit-index localparams BIT_NW = 8 .. BIT_C = 4 .. BIT_SE = 0, shared with `conway`.
  - FSM state encoding IDLE/LOAD/FLUSH.
- One natural sub-module: `shift_line` — parameterised-length serial shift register with enable and synchronous clear, exposing the full vector for tapping.

Test Plan:
- W=H=3, all cells 1, continuous in_valid -> 9 pulses. (1,1) = 9'h1FF; (0,0) = 9'h01B; (2,2) = 9'h1B0; (0,1) = 9'h03F. frame_done coincides with (2,2).
- W=H=3, only (1,1) alive -> (0,0) = 9'h001; (1,1) = 9'h010; (2,2) = 9'h100; (0,1) = 9'h002; all other windows contain only the single live bit at the mirrored position.
- W=4, H=3, in_valid toggled 1/0 every cycle -> same 12 windows as the gap-free run, in raster order; out_row/out_col run 0/0 .. 2/3; no extra pulses.
- start pulsed again mid-LOAD -> ignored; frame completes with 9 windows. in_valid asserted while IDLE -> no shift, no out_valid.
- reset asserted after 5 cells -> next cycle busy = 0, out_valid = 0, outputs 0. A following start plus full frame yields correct windows with no stale neighbours.
- Stream output into `conway` (W=H=3, blinker: row 1 alive) -> next-generation outputs show only column 1 alive.
